// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared types and constants for the pipeline hazard controller.
//   CPU_REG_W    : default register id width (32 architectural registers)
//   MUL_LAT_MAX  : deepest supported MUL pipe; sizes the in-flight counter
//   INFLIGHT_W   : width of the in-flight tag count (0..MUL_LAT_MAX)
//   reg_id_t     : architectural register id
//   mul_tag_t    : one MUL tag-pipe stage {valid, destination}
//   popcount_tags: counts valid stages of a (zero-padded) tag-valid vector
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int CPU_REG_W   = 5;
  localparam int MUL_LAT_MAX = 8;
  localparam int INFLIGHT_W  = 4;

  typedef logic [CPU_REG_W-1:0] reg_id_t;

  typedef struct packed {
    logic    v;
    reg_id_t rd;
  } mul_tag_t;

  // Number of set bits in a tag-valid vector padded to MUL_LAT_MAX bits.
  function automatic logic [INFLIGHT_W-1:0] popcount_tags(
    input logic [MUL_LAT_MAX-1:0] bits
  );
    logic [INFLIGHT_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < MUL_LAT_MAX; i++) begin
      sum = sum + {{(INFLIGHT_W-1){1'b0}}, bits[i]};
    end
    return sum;
  endfunction

endpackage : cpu_pkg

// File: rtl/cpu_mul_tag_pipe.sv
// -----------------------------------------------------------------------------
// cpu_mul_tag_pipe
// Shift register mirroring the MUL execution pipe. Stage 0 captures the MUL
// accepted from decode this cycle; the last stage is the MUL writeback cycle.
// The pipe advances every cycle regardless of pipeline freezes, because the
// MUL unit itself never stalls once an operation has been issued.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset (clears all tags)
//   push_v_i       : a MUL is issued this cycle
//   push_rd_i      : destination of the issued MUL
//   ra_id_i/rb_id_i: decode source ids to compare against every stage
//   rd_id_i        : decode destination id to compare against every stage
//   valid_o        : per-stage valid bits
//   ra/rb/rd_match_o: per-stage "valid and id equal" vectors
//   wb_rd_o        : destination held in the writeback (last) stage
// -----------------------------------------------------------------------------
module cpu_mul_tag_pipe #(
  parameter int REG_W   = 5,
  parameter int MUL_LAT = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               push_v_i,
  input  logic [REG_W-1:0]   push_rd_i,
  input  logic [REG_W-1:0]   ra_id_i,
  input  logic [REG_W-1:0]   rb_id_i,
  input  logic [REG_W-1:0]   rd_id_i,
  output logic [MUL_LAT-1:0] valid_o,
  output logic [MUL_LAT-1:0] ra_match_o,
  output logic [MUL_LAT-1:0] rb_match_o,
  output logic [MUL_LAT-1:0] rd_match_o,
  output logic [REG_W-1:0]   wb_rd_o
);

  logic [MUL_LAT-1:0] v_q;
  logic [REG_W-1:0]   rd_q [MUL_LAT];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q <= '0;
      for (int k = 0; k < MUL_LAT; k++) begin
        rd_q[k] <= '0;
      end
    end else begin
      v_q[0]  <= push_v_i;
      rd_q[0] <= push_rd_i;
      for (int k = 1; k < MUL_LAT; k++) begin
        v_q[k]  <= v_q[k-1];
        rd_q[k] <= rd_q[k-1];
      end
    end
  end

  always_comb begin
    ra_match_o = '0;
    rb_match_o = '0;
    rd_match_o = '0;
    for (int k = 0; k < MUL_LAT; k++) begin
      ra_match_o[k] = v_q[k] && (rd_q[k] == ra_id_i);
      rb_match_o[k] = v_q[k] && (rd_q[k] == rb_id_i);
      rd_match_o[k] = v_q[k] && (rd_q[k] == rd_id_i);
    end
  end

  assign valid_o = v_q;
  assign wb_rd_o = rd_q[MUL_LAT-1];

endmodule : cpu_mul_tag_pipe

// File: rtl/cpu_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_hazard_ctrl
// Decides each cycle whether the decode instruction may issue (operands come
// from the register file or the bypass network) or must stall. Tracks in-flight
// MUL destinations, detects MUL read-after-write, load-use and WAW-against-MUL
// hazards, and drives the fetch/decode stall and the execute bubble.
// Parameters:
//   REG_W   register id width
//   MUL_LAT cycles from MUL issue to its writeback cycle (2..8)
//   PERF_W  width of the stall performance counter
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   dec_valid                         decode holds a valid instruction
//   dec_ra_id/dec_rb_id               decode source ids
//   dec_ra_used/dec_rb_used           sources actually read
//   dec_rd_id, dec_wr_rd              decode destination and write enable
//   dec_is_mul                        decode instruction goes to the MUL pipe
//   ex_is_load, ex_rd_id              load in execute and its destination
//   mem_busy                          dcache miss, freezes fetch/decode/execute
//   flush                             branch redirect kills decode this cycle
//   mul_wb_valid, mul_wb_rd           MUL unit writeback, cross-checked
//   stall_fetch/stall_decode          hold PC/fetch and decode registers
//   bubble_execute                    insert NOP into execute
//   mul_issue                         decode MUL accepted this cycle
//   mul_inflight                      number of valid tag-pipe stages
//   mul_tag_err                       sticky MUL writeback disagreement
//   perf_stall_cnt                    saturating count of decode stall cycles
// Stall/issue handshake: decode presents dec_valid; the instruction is taken
// in any cycle where stall_decode is low (or it is killed by flush). A held
// instruction keeps its decode inputs stable until taken.
// -----------------------------------------------------------------------------
module cpu_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int REG_W   = CPU_REG_W,
  parameter int MUL_LAT = 5,
  parameter int PERF_W  = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  dec_valid,
  input  logic [REG_W-1:0]      dec_ra_id,
  input  logic [REG_W-1:0]      dec_rb_id,
  input  logic                  dec_ra_used,
  input  logic                  dec_rb_used,
  input  logic [REG_W-1:0]      dec_rd_id,
  input  logic                  dec_wr_rd,
  input  logic                  dec_is_mul,
  input  logic                  ex_is_load,
  input  logic [REG_W-1:0]      ex_rd_id,
  input  logic                  mem_busy,
  input  logic                  flush,
  input  logic                  mul_wb_valid,
  input  logic [REG_W-1:0]      mul_wb_rd,
  output logic                  stall_fetch,
  output logic                  stall_decode,
  output logic                  bubble_execute,
  output logic                  mul_issue,
  output logic [INFLIGHT_W-1:0] mul_inflight,
  output logic                  mul_tag_err,
  output logic [PERF_W-1:0]     perf_stall_cnt
);

  if (MUL_LAT < 2 || MUL_LAT > MUL_LAT_MAX) begin : g_bad_mul_lat
    $error("cpu_hazard_ctrl: MUL_LAT out of range 2..8");
  end

  // ---------------------------------------------------------------------------
  // MUL tag pipe
  // ---------------------------------------------------------------------------
  logic [MUL_LAT-1:0] tag_v;
  logic [MUL_LAT-1:0] ra_match;
  logic [MUL_LAT-1:0] rb_match;
  logic [MUL_LAT-1:0] rd_match;
  logic [REG_W-1:0]   wb_rd;

  cpu_mul_tag_pipe #(
    .REG_W   (REG_W),
    .MUL_LAT (MUL_LAT)
  ) u_tag_pipe (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_v_i   (mul_issue),
    .push_rd_i  (dec_rd_id),
    .ra_id_i    (dec_ra_id),
    .rb_id_i    (dec_rb_id),
    .rd_id_i    (dec_rd_id),
    .valid_o    (tag_v),
    .ra_match_o (ra_match),
    .rb_match_o (rb_match),
    .rd_match_o (rd_match),
    .wb_rd_o    (wb_rd)
  );

  // Source reads only conflict with stages below MUL_LAT-2: the stage at
  // MUL_LAT-2 reaches writeback exactly when the reader is in execute, where
  // the forwarding unit supplies it. A write-after-write must wait until the
  // MUL has reached its writeback stage so the younger write lands last.
  logic [MUL_LAT-1:0] src_mask;
  logic [MUL_LAT-1:0] waw_mask;

  always_comb begin
    src_mask = '0;
    waw_mask = '0;
    for (int k = 0; k < MUL_LAT; k++) begin
      src_mask[k] = (k < MUL_LAT - 2);
      waw_mask[k] = (k < MUL_LAT - 1);
    end
  end

  // ---------------------------------------------------------------------------
  // Hazard detection (register 0 is hardwired zero and never conflicts)
  // ---------------------------------------------------------------------------
  logic ra_live;
  logic rb_live;
  logic src_hit_a;
  logic src_hit_b;
  logic load_use;
  logic waw_mul;
  logic hazard;

  always_comb begin
    ra_live   = dec_valid && dec_ra_used && (dec_ra_id != '0);
    rb_live   = dec_valid && dec_rb_used && (dec_rb_id != '0);
    src_hit_a = ra_live && (|(ra_match & src_mask));
    src_hit_b = rb_live && (|(rb_match & src_mask));
    load_use  = ex_is_load && (ex_rd_id != '0) &&
                ((ra_live && (dec_ra_id == ex_rd_id)) ||
                 (rb_live && (dec_rb_id == ex_rd_id)));
    waw_mul   = dec_valid && dec_wr_rd && !dec_is_mul && (dec_rd_id != '0) &&
                (|(rd_match & waw_mask));
    hazard    = src_hit_a || src_hit_b || load_use || waw_mul;
  end

  // Flush outranks everything for the decode instruction, but a cache miss
  // still freezes the front end. No bubble under mem_busy: execute is frozen.
  always_comb begin
    stall_decode   = mem_busy || (hazard && !flush);
    stall_fetch    = stall_decode;
    bubble_execute = !mem_busy && hazard && !flush;
    mul_issue      = dec_valid && dec_is_mul && !stall_decode && !flush;
  end

  // ---------------------------------------------------------------------------
  // In-flight count
  // ---------------------------------------------------------------------------
  logic [MUL_LAT_MAX-1:0] tag_v_pad;

  always_comb begin
    tag_v_pad                = '0;
    tag_v_pad[MUL_LAT-1:0]   = tag_v;
    mul_inflight             = popcount_tags(tag_v_pad);
  end

  // ---------------------------------------------------------------------------
  // Writeback cross-check and stall counter
  // ---------------------------------------------------------------------------
  logic              tag_err_q;
  logic              tag_err_d;
  logic [PERF_W-1:0] perf_q;
  logic [PERF_W-1:0] perf_d;
  logic              wb_v;

  always_comb begin
    wb_v      = tag_v[MUL_LAT-1];
    tag_err_d = tag_err_q ||
                (mul_wb_valid != wb_v) ||
                (wb_v && (mul_wb_rd != wb_rd));
    perf_d    = perf_q;
    if (stall_decode && (perf_q != {PERF_W{1'b1}})) begin
      perf_d = perf_q + {{(PERF_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_err_q <= 1'b0;
      perf_q    <= '0;
    end else begin
      tag_err_q <= tag_err_d;
      perf_q    <= perf_d;
    end
  end

  assign mul_tag_err    = tag_err_q;
  assign perf_stall_cnt = perf_q;

endmodule : cpu_hazard_ctrl

// File: tb/tb_cpu_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_hazard_ctrl
// Directed scenarios plus randomized traffic. The reference model keeps a list
// of issued MULs with their issue cycle and derives hazards from the age of
// each MUL; it also plays the MUL unit, driving mul_wb_* MUL_LAT cycles after
// issue. A second instance with a 4-bit stall counter exercises saturation.
// -----------------------------------------------------------------------------
module tb_cpu_hazard_ctrl;

  localparam int REG_W    = 5;
  localparam int MUL_LAT  = 5;
  localparam int PERF_W   = 32;
  localparam int PERF_S_W = 4;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic             dec_valid, dec_ra_used, dec_rb_used, dec_wr_rd, dec_is_mul;
  logic [REG_W-1:0] dec_ra_id, dec_rb_id, dec_rd_id, ex_rd_id, mul_wb_rd;
  logic             ex_is_load, mem_busy, flush, mul_wb_valid;

  logic              stall_fetch, stall_decode, bubble_execute, mul_issue, mul_tag_err;
  logic [3:0]        mul_inflight;
  logic [PERF_W-1:0] perf_stall_cnt;

  logic                s_stall_fetch, s_stall_decode, s_bubble_execute, s_mul_issue, s_mul_tag_err;
  logic [3:0]          s_mul_inflight;
  logic [PERF_S_W-1:0] s_perf_stall_cnt;

  cpu_hazard_ctrl #(.REG_W(REG_W), .MUL_LAT(MUL_LAT), .PERF_W(PERF_W)) dut (
    .clk(clk), .reset_n(reset_n), .dec_valid(dec_valid),
    .dec_ra_id(dec_ra_id), .dec_rb_id(dec_rb_id),
    .dec_ra_used(dec_ra_used), .dec_rb_used(dec_rb_used),
    .dec_rd_id(dec_rd_id), .dec_wr_rd(dec_wr_rd), .dec_is_mul(dec_is_mul),
    .ex_is_load(ex_is_load), .ex_rd_id(ex_rd_id), .mem_busy(mem_busy), .flush(flush),
    .mul_wb_valid(mul_wb_valid), .mul_wb_rd(mul_wb_rd),
    .stall_fetch(stall_fetch), .stall_decode(stall_decode), .bubble_execute(bubble_execute),
    .mul_issue(mul_issue), .mul_inflight(mul_inflight), .mul_tag_err(mul_tag_err),
    .perf_stall_cnt(perf_stall_cnt)
  );

  cpu_hazard_ctrl #(.REG_W(REG_W), .MUL_LAT(MUL_LAT), .PERF_W(PERF_S_W)) dut_s (
    .clk(clk), .reset_n(reset_n), .dec_valid(dec_valid),
    .dec_ra_id(dec_ra_id), .dec_rb_id(dec_rb_id),
    .dec_ra_used(dec_ra_used), .dec_rb_used(dec_rb_used),
    .dec_rd_id(dec_rd_id), .dec_wr_rd(dec_wr_rd), .dec_is_mul(dec_is_mul),
    .ex_is_load(ex_is_load), .ex_rd_id(ex_rd_id), .mem_busy(mem_busy), .flush(flush),
    .mul_wb_valid(mul_wb_valid), .mul_wb_rd(mul_wb_rd),
    .stall_fetch(s_stall_fetch), .stall_decode(s_stall_decode), .bubble_execute(s_bubble_execute),
    .mul_issue(s_mul_issue), .mul_inflight(s_mul_inflight), .mul_tag_err(s_mul_tag_err),
    .perf_stall_cnt(s_perf_stall_cnt)
  );

  logic [8:0]  obs_vec;
  logic [12:0] obs_s;
  assign obs_vec = {stall_fetch, stall_decode, bubble_execute, mul_issue, mul_inflight, mul_tag_err};
  assign obs_s   = {s_stall_fetch, s_stall_decode, s_bubble_execute, s_mul_issue, s_mul_inflight,
                    s_mul_tag_err, s_perf_stall_cnt};

  // ---------------------------------------------------------------- reference model
  typedef struct {
    int rd;
    int t;
  } mul_rec_t;

  mul_rec_t          mq[$];
  int                cyc = 0;
  int                checks = 0;
  int                errors = 0;
  logic [PERF_W-1:0] perf_m;
  logic [PERF_S_W-1:0] perf_s_m;
  bit                err_m;
  bit                inject_arm;
  logic [8:0]        exp_vec;
  bit                exp_stall;
  bit                exp_issue;

  // A MUL issued in cycle t is "age" cycles old in cycle t+age; it writes back
  // at age MUL_LAT. Readers conflict while it is still more than one cycle
  // away from writeback; a younger writer must wait for its writeback.
  function automatic void model_eval();
    bit hit_a, hit_b, lu, waw, haz, bub;
    int infl, age;
    hit_a = 0; hit_b = 0; waw = 0; infl = 0;
    foreach (mq[i]) begin
      age = cyc - mq[i].t;
      if (age >= 1 && age <= MUL_LAT) infl++;
      if (age <= MUL_LAT - 2) begin
        if (mq[i].rd == int'(dec_ra_id)) hit_a = 1;
        if (mq[i].rd == int'(dec_rb_id)) hit_b = 1;
      end
      if (age <= MUL_LAT - 1 && mq[i].rd == int'(dec_rd_id)) waw = 1;
    end
    hit_a = hit_a && dec_valid && dec_ra_used && dec_ra_id != 0;
    hit_b = hit_b && dec_valid && dec_rb_used && dec_rb_id != 0;
    lu    = ex_is_load && dec_valid && ex_rd_id != 0 &&
            ((dec_ra_used && dec_ra_id == ex_rd_id) || (dec_rb_used && dec_rb_id == ex_rd_id));
    waw   = waw && dec_valid && dec_wr_rd && !dec_is_mul && dec_rd_id != 0;
    haz   = hit_a || hit_b || lu || waw;
    exp_stall = mem_busy || (haz && !flush);
    bub       = !mem_busy && haz && !flush;
    exp_issue = dec_valid && dec_is_mul && !exp_stall && !flush;
    exp_vec   = {exp_stall, exp_stall, bub, exp_issue, 4'(infl), err_m};
  endfunction

  // ---------------------------------------------------------------- driver tasks
  task automatic idle();
    dec_valid = 0; dec_ra_used = 0; dec_rb_used = 0; dec_wr_rd = 0; dec_is_mul = 0;
    dec_ra_id = 0; dec_rb_id = 0; dec_rd_id = 0; ex_is_load = 0; ex_rd_id = 0;
    mem_busy = 0; flush = 0;
  endtask

  task automatic set_dec(input bit is_mul, input int rd, input int ra, input int rb);
    dec_valid = 1; dec_is_mul = is_mul; dec_wr_rd = 1; dec_rd_id = REG_W'(rd);
    dec_ra_id = REG_W'(ra); dec_rb_id = REG_W'(rb); dec_ra_used = 1; dec_rb_used = 1;
  endtask

  task automatic model_reset();
    mq.delete(); perf_m = '0; perf_s_m = '0; err_m = 0;
    mul_wb_valid = 0; mul_wb_rd = '0;
  endtask

  // Advance one clock: update the model with the values sampled at the edge,
  // then play the MUL unit's writeback for the new cycle.
  task automatic tick();
    int wb_idx;
    @(posedge clk);
    if (reset_n) begin
      model_eval();
      wb_idx = -1;
      foreach (mq[i]) if (cyc - mq[i].t == MUL_LAT) wb_idx = i;
      if (wb_idx < 0) begin
        if (mul_wb_valid !== 1'b0) err_m = 1;
      end else if (mul_wb_valid !== 1'b1 || int'(mul_wb_rd) != mq[wb_idx].rd) begin
        err_m = 1;
      end
      if (exp_stall) begin
        if (perf_m != '1) perf_m++;
        if (perf_s_m != '1) perf_s_m++;
      end
      if (exp_issue) mq.push_back('{rd: int'(dec_rd_id), t: cyc});
      cyc++;
      while (mq.size() > 0 && cyc - mq[0].t > MUL_LAT) void'(mq.pop_front());
    end
    #1;
    mul_wb_valid = 0;
    mul_wb_rd    = '0;
    foreach (mq[i]) begin
      if (cyc - mq[i].t == MUL_LAT) begin
        mul_wb_valid = 1;
        mul_wb_rd    = REG_W'(mq[i].rd);
        if (inject_arm) begin
          mul_wb_rd  = 5'd7;
          inject_arm = 0;
        end
      end
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    for (int c = 0; c < 5; c++) begin
      if (c == 3) reset_n = 1;
      @(negedge clk); model_eval();
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL reset c=%0d outputs got=%b want=%b", c, obs_vec, exp_vec); end
      checks++;
      if (perf_stall_cnt !== perf_m) begin errors++; $display("FAIL reset c=%0d perf got=%0d want=%0d", c, perf_stall_cnt, perf_m); end
      checks++;
      if (obs_s !== {exp_vec, perf_s_m}) begin errors++; $display("FAIL reset c=%0d small got=%b want=%b", c, obs_s, {exp_vec, perf_s_m}); end
      checks++;
      if ({obs_vec, perf_stall_cnt} !== '0) begin errors++; $display("FAIL reset_zero c=%0d got=%b want=0", c, obs_vec); end
      tick();
    end
  endtask

  task automatic test_mul_raw();
    int stalls = 0;
    bit issued = 0;
    for (int c = 0; c < 12; c++) begin
      idle();
      if (c == 0) set_dec(1, 3, 1, 2);
      else if (!issued) set_dec(0, 4, 3, 1);
      @(negedge clk); model_eval();
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL mul_raw c=%0d outputs got=%b want=%b", c, obs_vec, exp_vec); end
      checks++;
      if (perf_stall_cnt !== perf_m) begin errors++; $display("FAIL mul_raw c=%0d perf got=%0d want=%0d", c, perf_stall_cnt, perf_m); end
      checks++;
      if (obs_s !== {exp_vec, perf_s_m}) begin errors++; $display("FAIL mul_raw c=%0d small got=%b want=%b", c, obs_s, {exp_vec, perf_s_m}); end
      if (c == 0) begin
        checks++;
        if (mul_issue !== 1'b1) begin errors++; $display("FAIL mul_raw_issue got=%b want=1", mul_issue); end
      end else if (!issued) begin
        if (stall_decode) stalls++; else issued = 1;
      end
      tick();
    end
    checks++;
    if (stalls !== 3) begin errors++; $display("FAIL mul_raw_stalls got=%0d want=3", stalls); end
    checks++;
    if (mul_tag_err !== 1'b0) begin errors++; $display("FAIL mul_raw_err got=%b want=0", mul_tag_err); end
  endtask

  task automatic test_load_use();
    for (int c = 0; c < 4; c++) begin
      idle();
      if (c < 2) begin
        set_dec(0, 6, 5, 2);
        ex_is_load = (c == 0);
        ex_rd_id   = (c == 0) ? 5'd5 : 5'd0;
      end
      @(negedge clk); model_eval();
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL load_use c=%0d outputs got=%b want=%b", c, obs_vec, exp_vec); end
      checks++;
      if (perf_stall_cnt !== perf_m) begin errors++; $display("FAIL load_use c=%0d perf got=%0d want=%0d", c, perf_stall_cnt, perf_m); end
      checks++;
      if (obs_s !== {exp_vec, perf_s_m}) begin errors++; $display("FAIL load_use c=%0d small got=%b want=%b", c, obs_s, {exp_vec, perf_s_m}); end
      if (c < 2) begin
        checks++;
        if ({stall_decode, bubble_execute} !== ((c == 0) ? 2'b11 : 2'b00)) begin
          errors++; $display("FAIL load_use_stall c=%0d got=%b want=%b", c, {stall_decode, bubble_execute}, (c == 0) ? 2'b11 : 2'b00);
        end
      end
      tick();
    end
  endtask

  task automatic test_waw();
    int stalls = 0;
    bit issued = 0;
    for (int c = 0; c < 10; c++) begin
      idle();
      if (c == 0) set_dec(1, 3, 1, 2);
      else if (c >= 2 && !issued) set_dec(0, 3, 1, 2);
      @(negedge clk); model_eval();
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL waw c=%0d outputs got=%b want=%b", c, obs_vec, exp_vec); end
      checks++;
      if (perf_stall_cnt !== perf_m) begin errors++; $display("FAIL waw c=%0d perf got=%0d want=%0d", c, perf_stall_cnt, perf_m); end
      checks++;
      if (obs_s !== {exp_vec, perf_s_m}) begin errors++; $display("FAIL waw c=%0d small got=%b want=%b", c, obs_s, {exp_vec, perf_s_m}); end
      if (c >= 2 && !issued) begin
        if (stall_decode) stalls++; else issued = 1;
      end
      tick();
    end
    checks++;
    if (stalls !== 3) begin errors++; $display("FAIL waw_stalls got=%0d want=3", stalls); end
  endtask

  task automatic test_mem_busy();
    int stalls = 0;
    int bubbles = 0;
    for (int c = 0; c < 9; c++) begin
      idle();
      if (c == 0) set_dec(1, 2, 1, 1);
      else if (c <= 4) begin set_dec(0, 8, 9, 10); mem_busy = 1; end
      @(negedge clk); model_eval();
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL mem_busy c=%0d outputs got=%b want=%b", c, obs_vec, exp_vec); end
      checks++;
      if (perf_stall_cnt !== perf_m) begin errors++; $display("FAIL mem_busy c=%0d perf got=%0d want=%0d", c, perf_stall_cnt, perf_m); end
      checks++;
      if (obs_s !== {exp_vec, perf_s_m}) begin errors++; $display("FAIL mem_busy c=%0d small got=%b want=%b", c, obs_s, {exp_vec, perf_s_m}); end
      if (stall_decode) stalls++;
      if (bubble_execute) bubbles++;
      if (c == 4) begin
        checks++;
        if (mul_inflight !== 4'd1) begin errors++; $display("FAIL mem_busy_inflight got=%0d want=1", mul_inflight); end
      end
      tick();
    end
    checks++;
    if (stalls !== 4 || bubbles !== 0) begin errors++; $display("FAIL mem_busy_counts got=%0d/%0d want=4/0", stalls, bubbles); end
    checks++;
    if (mul_tag_err !== 1'b0) begin errors++; $display("FAIL mem_busy_err got=%b want=0", mul_tag_err); end
  endtask

  task automatic test_flush();
    for (int c = 0; c < 9; c++) begin
      idle();
      if (c == 0) set_dec(1, 3, 1, 2);
      else if (c == 1) begin set_dec(0, 5, 3, 1); flush = 1; end
      else if (c == 2) begin set_dec(1, 7, 1, 2); flush = 1; end
      else if (c == 3) set_dec(0, 5, 3, 1);
      @(negedge clk); model_eval();
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL flush c=%0d outputs got=%b want=%b", c, obs_vec, exp_vec); end
      checks++;
      if (perf_stall_cnt !== perf_m) begin errors++; $display("FAIL flush c=%0d perf got=%0d want=%0d", c, perf_stall_cnt, perf_m); end
      checks++;
      if (obs_s !== {exp_vec, perf_s_m}) begin errors++; $display("FAIL flush c=%0d small got=%b want=%b", c, obs_s, {exp_vec, perf_s_m}); end
      if (c == 1) begin
        checks++;
        if ({stall_decode, bubble_execute} !== 2'b00) begin errors++; $display("FAIL flush_hazard got=%b want=00", {stall_decode, bubble_execute}); end
      end
      if (c == 2) begin
        checks++;
        if ({mul_issue, mul_inflight} !== 5'b0_0001) begin errors++; $display("FAIL flush_mul got=%b want=00001", {mul_issue, mul_inflight}); end
      end
      if (c == 3) begin
        checks++;
        if (stall_decode !== 1'b1) begin errors++; $display("FAIL flush_retained got=%b want=1", stall_decode); end
      end
      tick();
    end
  endtask

  task automatic test_r0();
    for (int c = 0; c < 8; c++) begin
      idle();
      if (c == 0) set_dec(1, 0, 1, 2);
      else if (c == 1) begin set_dec(0, 2, 0, 0); ex_is_load = 1; ex_rd_id = 0; end
      else if (c == 2) set_dec(0, 0, 1, 2);
      @(negedge clk); model_eval();
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL r0 c=%0d outputs got=%b want=%b", c, obs_vec, exp_vec); end
      checks++;
      if (perf_stall_cnt !== perf_m) begin errors++; $display("FAIL r0 c=%0d perf got=%0d want=%0d", c, perf_stall_cnt, perf_m); end
      checks++;
      if (obs_s !== {exp_vec, perf_s_m}) begin errors++; $display("FAIL r0 c=%0d small got=%b want=%b", c, obs_s, {exp_vec, perf_s_m}); end
      if (c == 1 || c == 2) begin
        checks++;
        if (stall_decode !== 1'b0) begin errors++; $display("FAIL r0_stall c=%0d got=%b want=0", c, stall_decode); end
      end
      tick();
    end
  endtask

  task automatic test_tag_err_reset();
    inject_arm = 1;
    for (int c = 0; c < 14; c++) begin
      idle();
      if (c == 0) set_dec(1, 3, 1, 2);
      if (c == 8) set_dec(1, 4, 1, 2);
      if (c == 9) begin reset_n = 0; model_reset(); end
      if (c == 11) reset_n = 1;
      @(negedge clk); model_eval();
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL tag_err c=%0d outputs got=%b want=%b", c, obs_vec, exp_vec); end
      checks++;
      if (perf_stall_cnt !== perf_m) begin errors++; $display("FAIL tag_err c=%0d perf got=%0d want=%0d", c, perf_stall_cnt, perf_m); end
      checks++;
      if (obs_s !== {exp_vec, perf_s_m}) begin errors++; $display("FAIL tag_err c=%0d small got=%b want=%b", c, obs_s, {exp_vec, perf_s_m}); end
      if (c >= 6 && c <= 8) begin
        checks++;
        if (mul_tag_err !== 1'b1) begin errors++; $display("FAIL tag_err_sticky c=%0d got=%b want=1", c, mul_tag_err); end
      end
      if (c >= 9) begin
        checks++;
        if ({obs_vec, perf_stall_cnt} !== '0) begin errors++; $display("FAIL reset_mid c=%0d got=%b want=0", c, obs_vec); end
      end
      tick();
    end
  endtask

  task automatic test_perf_sat();
    for (int c = 0; c < 22; c++) begin
      idle();
      mem_busy = (c < 20);
      @(negedge clk); model_eval();
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL perf_sat c=%0d outputs got=%b want=%b", c, obs_vec, exp_vec); end
      checks++;
      if (perf_stall_cnt !== perf_m) begin errors++; $display("FAIL perf_sat c=%0d perf got=%0d want=%0d", c, perf_stall_cnt, perf_m); end
      checks++;
      if (obs_s !== {exp_vec, perf_s_m}) begin errors++; $display("FAIL perf_sat c=%0d small got=%b want=%b", c, obs_s, {exp_vec, perf_s_m}); end
      tick();
    end
    checks++;
    if (s_perf_stall_cnt !== 4'hF || perf_stall_cnt !== 32'd20) begin
      errors++; $display("FAIL perf_sat_final got=%0d/%0d want=15/20", s_perf_stall_cnt, perf_stall_cnt);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      dec_valid   = ($urandom_range(0, 3) != 0);
      dec_ra_id   = REG_W'($urandom_range(0, 3));
      dec_rb_id   = REG_W'($urandom_range(0, 3));
      dec_rd_id   = REG_W'($urandom_range(0, 3));
      dec_ra_used = 1'($urandom_range(0, 1));
      dec_rb_used = 1'($urandom_range(0, 1));
      dec_wr_rd   = 1'($urandom_range(0, 1));
      dec_is_mul  = ($urandom_range(0, 2) == 0);
      ex_is_load  = ($urandom_range(0, 2) == 0);
      ex_rd_id    = REG_W'($urandom_range(0, 3));
      mem_busy    = ($urandom_range(0, 7) == 0);
      flush       = ($urandom_range(0, 7) == 0);
      @(negedge clk); model_eval();
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL random c=%0d outputs got=%b want=%b", c, obs_vec, exp_vec); end
      checks++;
      if (perf_stall_cnt !== perf_m) begin errors++; $display("FAIL random c=%0d perf got=%0d want=%0d", c, perf_stall_cnt, perf_m); end
      checks++;
      if (obs_s !== {exp_vec, perf_s_m}) begin errors++; $display("FAIL random c=%0d small got=%b want=%b", c, obs_s, {exp_vec, perf_s_m}); end
      tick();
    end
  endtask

  // ---------------------------------------------------------------- sequence + report
  initial begin
    idle();
    inject_arm = 0;
    model_reset();
    test_reset();
    test_mul_raw();
    test_load_use();
    test_waw();
    test_mem_busy();
    test_flush();
    test_r0();
    test_tag_err_reset();
    test_perf_sat();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_cpu_hazard_ctrl
